// File: rtl/traffic_timer_pkg.sv
// Shared definitions for the traffic timer: counter width, FSM encodings,
// simulation prescale value and 7-segment patterns (used when TIMER_SEG_EN is defined).
package traffic_timer_pkg;

  // Counter width shared by the controller and the timer
  localparam int unsigned TIMER_CNT_W = 4;

  // Prescale value used in simulation instead of the 1 s board value
  localparam int unsigned SIM_TICK_DIV = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StCount = 2'd2,
    StDone  = 2'd3
  } timer_state_e;

  // Active-low 7-segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Hex digit to active-low 7-segment pattern
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/traffic_timer_if.sv
// Timer interface between the traffic light controller (master) and the
// countdown timer (slave). seg exists only when TIMER_SEG_EN is defined.
interface traffic_timer_if
  import traffic_timer_pkg::*;
#(
  parameter int unsigned CNT_W = TIMER_CNT_W
) ();

  logic             timer_load;
  logic             timer_en;
  logic [CNT_W-1:0] timer_init;
  logic [CNT_W-1:0] timer_out;
  logic             tick;
  logic             expired;
`ifdef TIMER_SEG_EN
  logic [6:0]       seg;
`endif

  modport master (
    output timer_load,
    output timer_en,
    output timer_init,
    input  timer_out,
    input  tick,
    input  expired
`ifdef TIMER_SEG_EN
    ,
    input  seg
`endif
  );

  modport slave (
    input  timer_load,
    input  timer_en,
    input  timer_init,
    output timer_out,
    output tick,
    output expired
`ifdef TIMER_SEG_EN
    ,
    output seg
`endif
  );

endinterface

// File: rtl/traffic_timer_tick_prescaler.sv
// Prescaler: counts enabled cycles 0..TICK_DIV-1 and raises a combinational
// wrap strobe in the cycle where it rolls back to 0. clr has priority over en.
module traffic_timer_tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign wrap    = en && !clr && at_last;

  // Prescale counter: clear, advance when enabled, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= at_last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_timer.sv
// Countdown timer on the responder side of the traffic light controller.
// One count lasts TICK_DIV enabled clock cycles. Optional macro TIMER_SEG_EN
// adds a registered 7-segment decode of timer_out on the interface.
module traffic_timer
  import traffic_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = TIMER_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  traffic_timer_if.slave   tmr
);

  timer_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             expired_q, expired_d;
  logic             pre_clr, pre_en, wrap;
  logic             load;

  assign load = tmr.timer_load;

  traffic_timer_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .wrap (wrap)
  );

  // Prescaler control; the enabled ARMED cycle that starts counting already
  // counts as the first prescaled cycle, so the first decrement lands exactly
  // TICK_DIV enabled cycles after counting begins.
  always_comb begin
    pre_clr = load;
    pre_en  = 1'b0;
    case (state_q)
      StIdle:  pre_en = 1'b0;
      StArmed: pre_en = tmr.timer_en && !load && (cnt_q != '0);
      StCount: pre_en = tmr.timer_en && !load;
      StDone:  pre_en = 1'b0;
      default: pre_clr = 1'b1;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
    end
  end

  // Next-state logic: load overrides everything, enable drives progress
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = StArmed;
    end else begin
      case (state_q)
        StIdle:  state_d = StIdle;
        StArmed: begin
          if (tmr.timer_en) begin
            state_d = (cnt_q == '0) ? StDone : StCount;
          end
        end
        StCount: begin
          if (cnt_q == '0) begin
            state_d = StDone;
          end else if (tmr.timer_en && wrap && (cnt_q == CNT_W'(1))) begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // Next values of the registered outputs; decrement is guarded so 0 never wraps
  always_comb begin
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    expired_d = (state_d == StDone);
    if (load) begin
      cnt_d = tmr.timer_init;
    end else begin
      case (state_q)
        StIdle, StArmed, StDone: cnt_d = cnt_q;
        StCount: begin
          tick_d = wrap;
          if (wrap && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          cnt_d     = '0;
          expired_d = 1'b0;
        end
      endcase
    end
  end

  assign tmr.timer_out = cnt_q;
  assign tmr.tick      = tick_q;
  assign tmr.expired   = expired_q;

`ifdef TIMER_SEG_EN
  logic [6:0] seg_q;

  // Display register, one cycle behind timer_out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_0;
    end else begin
      seg_q <= hex_to_seg(4'(cnt_q));
    end
  end

  assign tmr.seg = seg_q;
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer with TICK_DIV=4. Expected values come
// from a small cycle-level reference model and travel through a scoreboard queue.
module tb_traffic_timer
  import traffic_timer_pkg::*;
();

  localparam int TDIV = 4;

  // Reference model state codes
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_COUNT = 2;
  localparam int M_DONE  = 3;

  typedef struct {
    int out;
    int expired;
    int tick;
    int seg;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  int m_out;
  int m_pre;
  int m_state;
  int m_tick;

  traffic_timer_if #(.CNT_W(TIMER_CNT_W)) tmr ();

  traffic_timer #(
    .TICK_DIV (TDIV),
    .CNT_W    (TIMER_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tmr (tmr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Independent 7-segment reference, active-low gfedcba
  function automatic int seg_ref(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic model_reset();
    m_out   = 0;
    m_pre   = 0;
    m_state = M_IDLE;
    m_tick  = 0;
  endtask

  // One clock edge of the reference model
  task automatic model_edge(input int ld, input int en, input int init);
    m_tick = 0;
    if (ld != 0) begin
      m_out   = init;
      m_pre   = 0;
      m_state = M_ARMED;
    end else if (en != 0 && (m_state == M_ARMED || m_state == M_COUNT)) begin
      if (m_out == 0) begin
        m_state = M_DONE;
      end else begin
        m_state = M_COUNT;
        m_pre++;
        if (m_pre == TDIV) begin
          m_pre  = 0;
          m_out  = m_out - 1;
          m_tick = 1;
          if (m_out == 0) m_state = M_DONE;
        end
      end
    end
  endtask

  // Drive one cycle, push the expectation, compare after the edge
  task automatic step(input int ld, input int en, input int init);
    exp_t e;
    int   prev;
    @(negedge clk);
    tmr.timer_load = (ld != 0);
    tmr.timer_en   = (en != 0);
    tmr.timer_init = init[TIMER_CNT_W-1:0];
    prev = m_out;
    model_edge(ld, en, init);
    e.out     = m_out;
    e.expired = (m_state == M_DONE) ? 1 : 0;
    e.tick    = m_tick;
    e.seg     = seg_ref(prev);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("timer_out", 32'(tmr.timer_out), 32'(e.out));
      check("expired", 32'(tmr.expired), 32'(e.expired));
      check("tick", 32'(tmr.tick), 32'(e.tick));
`ifdef TIMER_SEG_EN
      check("seg", 32'(tmr.seg), 32'(e.seg));
`endif
    end
  endtask

  task automatic run(input int n, input int en);
    for (int i = 0; i < n; i++) step(0, en, 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    rst = 1'b1;
    tmr.timer_load = 1'b0;
    tmr.timer_en   = 1'b0;
    tmr.timer_init = '0;
    #1;
    check("rst_out", 32'(tmr.timer_out), 32'd0);
    check("rst_expired", 32'(tmr.expired), 32'd0);
    check("rst_tick", 32'(tmr.tick), 32'd0);
`ifdef TIMER_SEG_EN
    check("rst_seg", 32'(tmr.seg), 32'h40);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Load 9, count all the way down, then dwell in DONE
    step(1, 0, 9);
    check("load9_out", 32'(tmr.timer_out), 32'd9);
    run(4, 1);
    check("load9_first_dec", 32'(tmr.timer_out), 32'd8);
    run(32, 1);
    check("load9_zero", 32'(tmr.timer_out), 32'd0);
    check("load9_expired", 32'(tmr.expired), 32'd1);
    run(20, 1);
    check("load9_no_underflow", 32'(tmr.timer_out), 32'd0);

    // Load 5 with a pause mid-count
    step(1, 0, 5);
    run(4, 1);
    check("pause_first_dec", 32'(tmr.timer_out), 32'd4);
    run(2, 1);
    run(10, 0);
    check("pause_frozen", 32'(tmr.timer_out), 32'd4);
    run(1, 1);
    check("pause_resume1", 32'(tmr.timer_out), 32'd4);
    run(1, 1);
    check("pause_resume2", 32'(tmr.timer_out), 32'd3);
    run(16, 1);

    // Load and enable in the same cycle: load wins
    step(1, 1, 3);
    check("ld_en_out", 32'(tmr.timer_out), 32'd3);
    run(3, 1);
    check("ld_en_hold", 32'(tmr.timer_out), 32'd3);
    run(1, 1);
    check("ld_en_dec", 32'(tmr.timer_out), 32'd2);
    run(8, 1);
    check("ld_en_done", 32'(tmr.expired), 32'd1);

    // Reload from DONE
    step(1, 1, 14);
    check("reload_expired", 32'(tmr.expired), 32'd0);
    check("reload_out", 32'(tmr.timer_out), 32'd14);
    run(55, 1);
    check("reload_before_zero", 32'(tmr.timer_out), 32'd1);
    run(1, 1);
    check("reload_zero", 32'(tmr.timer_out), 32'd0);
    check("reload_expired2", 32'(tmr.expired), 32'd1);

    // Asynchronous reset mid-count
    step(1, 0, 8);
    run(8, 1);
    check("pre_rst_out", 32'(tmr.timer_out), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", 32'(tmr.timer_out), 32'd0);
    check("async_rst_expired", 32'(tmr.expired), 32'd0);
    check("async_rst_tick", 32'(tmr.tick), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run(10, 1);
    check("idle_after_rst", 32'(tmr.timer_out), 32'd0);

    // Load 10 for the display path
    step(1, 0, 10);
    step(0, 0, 0);
`ifdef TIMER_SEG_EN
    check("seg_a", 32'(tmr.seg), 32'h08);
`endif
    run(4, 1);
    check("ten_to_nine", 32'(tmr.timer_out), 32'd9);
    run(1, 1);
`ifdef TIMER_SEG_EN
    check("seg_9", 32'(tmr.seg), 32'h10);
`endif
    run(3, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
